// File: rtl/array_check_pkg.sv
// rtl/array_check_pkg.sv - shared types and constants for the array order checker
//
// Purpose : FSM state encoding, element byte-size helper and the "no violation"
//           sentinel used by array_order_checker and its sub-modules.
// Ports   : none (package).
package array_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Bytes occupied by one array element in byte-addressed memory.
  function automatic int bytes_per_elem(input int data_w);
    return data_w / 8;
  endfunction

  // Wide all-ones value; users slice it down to their index width.
  localparam logic [63:0] NO_VIOL_ALL_ONES = '1;

endpackage

// File: rtl/order_cmp.sv
// rtl/order_cmp.sv - combinational adjacent-pair order violation comparator
//
// Purpose : flags when (prev, cur) is out of order for the requested direction.
//           Equal values never violate.
// Ports   : prev, cur    - element pair, prev read before cur
//           descending   - 0: prev > cur violates, 1: prev < cur violates
//           signed_cmp   - 1: two's-complement compare
//           viol         - pair is out of order
module order_cmp #(
  parameter int W = 32
) (
  input  logic [W-1:0] prev,
  input  logic [W-1:0] cur,
  input  logic         descending,
  input  logic         signed_cmp,
  output logic         viol
);

  logic gt;
  logic lt;

  always_comb begin
    if (signed_cmp) begin
      gt = $signed(prev) > $signed(cur);
      lt = $signed(prev) < $signed(cur);
    end else begin
      gt = prev > cur;
      lt = prev < cur;
    end
    viol = descending ? lt : gt;
  end

endmodule

// File: rtl/array_order_checker.sv
// rtl/array_order_checker.sv - scans an array in data memory and reports ordering
//
// Purpose : after start, reads length elements from base_addr one per cycle,
//           compares each returned element with the previous one and reports
//           pass, violation count and first violating index.
// Config  : `define ARRAY_ORDER_CHECKER_SUM_EN adds exp_sum/sum; pass then also
//           requires the modular sum of all elements to equal exp_sum.
// Ports   : clk, rst (async active-low)
//           start, base_addr, length, descending, signed_cmp - scan request
//           mem_rd, mem_addr, mem_rdata - memory read port (RD_LAT latency)
//           [exp_sum, sum]              - optional checksum
//           busy, done, pass, viol_count, first_viol - status / results
module array_order_checker
  import array_check_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              descending,
  input  logic              signed_cmp,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef ARRAY_ORDER_CHECKER_SUM_EN
  input  logic [DATA_W-1:0] exp_sum,
  output logic [DATA_W-1:0] sum,
`endif
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [LEN_W-1:0]  viol_count,
  output logic [LEN_W-1:0]  first_viol
);

  localparam int                BYTES_PER_ELEM = bytes_per_elem(DATA_W);
  localparam logic [ADDR_W-1:0] ADDR_STEP      = ADDR_W'(BYTES_PER_ELEM);
  localparam logic [LEN_W-1:0]  LEN_ONE        = LEN_W'(1);
  localparam logic [LEN_W-1:0]  NO_VIOL        = NO_VIOL_ALL_ONES[LEN_W-1:0];
  // Stage that holds the read whose data is on mem_rdata this cycle.
  localparam logic [RD_LAT-1:0] TOP_BIT        = RD_LAT'(1) << (RD_LAT - 1);

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issue_idx;
  logic               desc_q;
  logic               sgn_q;
  logic [RD_LAT-1:0]  vld_sr;
  logic [LEN_W-1:0]   idx_sr [RD_LAT];
  logic [DATA_W-1:0]  prev_q;
  logic               has_prev;
  logic               viol;
  logic               ret_vld;
  logic [LEN_W-1:0]   ret_idx;
  logic               pend_early;
  logic               order_ok;
`ifdef ARRAY_ORDER_CHECKER_SUM_EN
  logic [DATA_W-1:0]  exp_sum_q;
`endif

  assign mem_addr   = addr_q;
  assign busy       = (state != IDLE);
  assign ret_vld    = vld_sr[RD_LAT-1];
  assign ret_idx    = idx_sr[RD_LAT-1];
  // Reads still in flight other than the one returning this cycle; once none
  // remain, the final compare lands on the same edge that enters FIN.
  assign pend_early = |(vld_sr & ~TOP_BIT);
  assign order_ok   = (viol_count == '0);

  order_cmp #(.W(DATA_W)) u_cmp (
    .prev       (prev_q),
    .cur        (mem_rdata),
    .descending (desc_q),
    .signed_cmp (sgn_q),
    .viol       (viol)
  );

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = (length == '0) ? FIN : ISSUE;
      ISSUE: begin
        mem_rd = 1'b1;
        if (issue_idx == len_q - LEN_ONE) state_nxt = DRAIN;
      end
      DRAIN: if (!pend_early) state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      issue_idx  <= '0;
      desc_q     <= 1'b0;
      sgn_q      <= 1'b0;
      vld_sr     <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_sr[i] <= '0;
      prev_q     <= '0;
      has_prev   <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      viol_count <= '0;
      first_viol <= NO_VIOL;
`ifdef ARRAY_ORDER_CHECKER_SUM_EN
      sum        <= '0;
      exp_sum_q  <= '0;
`endif
    end else begin
      state <= state_nxt;
      done  <= 1'b0;

      // Latency tracker: index travels alongside its read strobe.
      vld_sr[0] <= mem_rd;
      idx_sr[0] <= issue_idx;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        vld_sr[i] <= vld_sr[i-1];
        idx_sr[i] <= idx_sr[i-1];
      end

      if (ret_vld) begin
        prev_q   <= mem_rdata;
        has_prev <= 1'b1;
`ifdef ARRAY_ORDER_CHECKER_SUM_EN
        sum      <= sum + mem_rdata;
`endif
        if (has_prev && viol) begin
          if (viol_count != '1) viol_count <= viol_count + LEN_ONE;
          if (viol_count == '0) first_viol <= ret_idx;
        end
      end

      case (state)
        IDLE: if (start) begin
          addr_q     <= base_addr;
          len_q      <= length;
          desc_q     <= descending;
          sgn_q      <= signed_cmp;
          issue_idx  <= '0;
          has_prev   <= 1'b0;
          pass       <= 1'b0;
          viol_count <= '0;
          first_viol <= NO_VIOL;
`ifdef ARRAY_ORDER_CHECKER_SUM_EN
          sum        <= '0;
          exp_sum_q  <= exp_sum;
`endif
        end
        ISSUE: begin
          addr_q    <= addr_q + ADDR_STEP;
          issue_idx <= issue_idx + LEN_ONE;
        end
        FIN: begin
          done <= 1'b1;
`ifdef ARRAY_ORDER_CHECKER_SUM_EN
          pass <= order_ok && (sum == exp_sum_q);
`else
          pass <= order_ok;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_array_order_checker.sv
// tb/tb_array_order_checker.sv - self-checking bench for array_order_checker
module tb_array_order_checker;

`ifdef ARRAY_ORDER_CHECKER_SUM_EN
  localparam int RD_LAT = 2;
  localparam bit SUM_ON = 1'b1;
`else
  localparam int RD_LAT = 1;
  localparam bit SUM_ON = 1'b0;
`endif
  localparam int NVEC = 11;

  typedef struct {
    logic [31:0] base;
    int          len;
    bit          desc;
    bit          sgn;
    bit          fix_sum;
    logic [31:0] exp_sum;
    bit          e_pass;
    int          e_viol;
    logic [15:0] e_first;
    int          d [10];
  } vec_t;

  typedef struct {
    bit          pass;
    int          viol;
    logic [15:0] first;
    int          lat;
    int          reads;
    logic [31:0] sum;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] length = '0;
  logic        descending = 1'b0;
  logic        signed_cmp = 1'b0;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        busy, done, pass;
  logic [15:0] viol_count, first_viol;
`ifdef ARRAY_ORDER_CHECKER_SUM_EN
  logic [31:0] exp_sum = '0;
  logic [31:0] sum;
`endif

  int          checks = 0;
  int          errors = 0;
  int          rd_cnt;
  bit          addr_bad;
  logic [31:0] cur_base;
  vec_t        vt [NVEC];
  exp_t        sb [$];

  logic [31:0]       mem [64];
  logic [31:0]       pipe_a [RD_LAT];
  logic [RD_LAT-1:0] pipe_v = '0;

  always #5 clk = ~clk;

  array_order_checker #(.DATA_W(32), .ADDR_W(32), .LEN_W(16), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .descending(descending), .signed_cmp(signed_cmp), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
`ifdef ARRAY_ORDER_CHECKER_SUM_EN
    .exp_sum(exp_sum), .sum(sum),
`endif
    .busy(busy), .done(done), .pass(pass), .viol_count(viol_count),
    .first_viol(first_viol)
  );

  // Memory model: data for a read appears RD_LAT cycles after its strobe.
  always @(posedge clk) begin
    pipe_a[0] <= mem_addr;
    pipe_v[0] <= mem_rd;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_v[i] <= pipe_v[i-1];
    end
  end
  assign mem_rdata = pipe_v[RD_LAT-1] ? mem[pipe_a[RD_LAT-1][7:2]] : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance one clock, sample just after the edge and audit any read strobe.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (mem_rd) begin
      if (mem_addr !== cur_base + 32'(rd_cnt * 4)) addr_bad = 1'b1;
      rd_cnt++;
    end
  endtask

  function automatic vec_t mk(input logic [31:0] base, input int len, input bit desc,
                              input bit sgn, input bit ep, input int ev,
                              input logic [15:0] ef);
    vec_t v;
    v.base = base; v.len = len; v.desc = desc; v.sgn = sgn;
    v.fix_sum = 1'b0; v.exp_sum = '0;
    v.e_pass = ep; v.e_viol = ev; v.e_first = ef;
    for (int i = 0; i < 10; i++) v.d[i] = 0;
    return v;
  endfunction

  function automatic logic [31:0] model_sum(input vec_t v);
    logic [31:0] s = '0;
    for (int i = 0; i < v.len; i++) s = s + 32'(v.d[i]);
    return s;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < v.len; i++) begin
      logic [31:0] a;
      a = v.base + 32'(i * 4);
      mem[a[7:2]] = 32'(v.d[i]);
    end
  endtask

  task automatic drive_start(input vec_t v);
    base_addr  = v.base;
    length     = 16'(v.len);
    descending = v.desc;
    signed_cmp = v.sgn;
`ifdef ARRAY_ORDER_CHECKER_SUM_EN
    exp_sum    = v.fix_sum ? v.exp_sum : model_sum(v);
`endif
    rd_cnt   = 0;
    addr_bad = 1'b0;
    cur_base = v.base;
    start    = 1'b1;
  endtask

  // Runs one scan; intr_at >= 1 pulses a bogus start that many cycles in.
  task automatic run_scan(input string tag, input vec_t v, input int intr_at);
    exp_t e;
    exp_t got;
    int   lat;
    load(v);
    e.pass  = v.e_pass;
    e.viol  = v.e_viol;
    e.first = v.e_first;
    e.lat   = (v.len == 0) ? 2 : v.len + RD_LAT + 2;
    e.reads = v.len;
    e.sum   = model_sum(v);
    sb.push_back(e);
    drive_start(v);
    lat = 0;
    do begin
      cycle();
      lat++;
      start = 1'b0;
      if (lat == 1) chk({tag, "_busy"}, busy, 1'b1);
      if (lat == intr_at) begin
        base_addr = 32'h40; length = 16'd2; descending = ~v.desc; start = 1'b1;
      end
    end while (!done && lat < 200);
    got = sb.pop_front();
    chk({tag, "_done_seen"}, done, 1'b1);
    chk({tag, "_latency"}, lat, got.lat);
    chk({tag, "_pass"}, pass, got.pass);
    chk({tag, "_viol_count"}, viol_count, got.viol);
    chk({tag, "_first_viol"}, first_viol, got.first);
    chk({tag, "_reads"}, rd_cnt, got.reads);
    chk({tag, "_addr_bad"}, addr_bad, 1'b0);
    chk({tag, "_busy_end"}, busy, 1'b0);
`ifdef ARRAY_ORDER_CHECKER_SUM_EN
    chk({tag, "_sum"}, sum, got.sum);
`endif
  endtask

  initial begin
    vt[0] = mk(32'd4336, 10, 0, 0, 1, 0, 16'hFFFF);
    vt[0].d = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    vt[1] = mk(32'd4336, 10, 0, 0, 0, 5, 16'd1);
    vt[1].d = '{5, 3, 8, 1, 9, 2, 7, 4, 6, 0};
    vt[2] = mk(32'd4336, 4, 1, 1, 1, 0, 16'hFFFF);
    vt[2].d = '{7, 0, -1, -5, 0, 0, 0, 0, 0, 0};
    vt[3] = mk(32'd4336, 4, 1, 0, 0, 1, 16'd2);
    vt[3].d = '{7, 0, -1, -5, 0, 0, 0, 0, 0, 0};
    vt[4] = mk(32'd4336, 0, 0, 0, 1, 0, 16'hFFFF);
    vt[5] = mk(32'd4400, 1, 0, 0, 1, 0, 16'hFFFF);
    vt[5].d = '{42, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[6] = mk(32'hFFFF_FFF8, 4, 0, 0, 1, 0, 16'hFFFF);
    vt[6].d = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0};
    vt[7] = mk(32'd4336, 4, 0, 1, 1, 0, 16'hFFFF);
    vt[7].d = '{-5, -1, 0, 7, 0, 0, 0, 0, 0, 0};
    vt[8] = mk(32'd4336, 4, 1, 0, 1, 0, 16'hFFFF);
    vt[8].d = '{3, 3, 3, 2, 0, 0, 0, 0, 0, 0};
    vt[9] = mk(32'd4336, 10, 0, 0, !SUM_ON, 0, 16'hFFFF);
    vt[9].d = '{1, 2, 2, 4, 5, 6, 7, 8, 9, 10};
    vt[9].fix_sum = 1'b1;
    vt[9].exp_sum = 32'd55;
    vt[10] = mk(32'd4336, 5, 1, 0, 0, 4, 16'd1);
    vt[10].d = '{1, 2, 3, 4, 5, 0, 0, 0, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_viol_count", viol_count, 16'h0);
    chk("rst_first_viol", first_viol, 16'hFFFF);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back table: each start lands in the previous scan's done cycle.
    for (int k = 0; k < NVEC; k++) run_scan($sformatf("vec%0d", k), vt[k], -1);

    cycle();
    chk("done_one_cycle", done, 1'b0);
    chk("pass_held", pass, vt[NVEC-1].e_pass);

    run_scan("busy_start", vt[0], 3);

    // Reset in the middle of a scan, then rescan from index 0.
    load(vt[1]);
    drive_start(vt[1]);
    for (int n = 0; n < 50 && rd_cnt < 3; n++) begin
      cycle();
      start = 1'b0;
    end
    chk("pre_rst_reads", rd_cnt, 3);
    rst = 1'b0;
    #1;
    chk("mid_rst_mem_rd", mem_rd, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_mem_addr", mem_addr, 32'h0);
    chk("mid_rst_viol_count", viol_count, 16'h0);
    chk("mid_rst_first_viol", first_viol, 16'hFFFF);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    run_scan("after_rst", vt[1], -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/array_order_checker.md
Name: array_order_checker

Overview:
- Synthesizable result checker that sits beside Data_Memory in CPU test tops.
- After the program finishes, it scans an N-element array in data memory through a read port and reports whether the array is ordered.
- Generalises the fixed-size sorted-array dump done in the bench: element width, length, base address, sort direction and signedness are all configurable.
- Also reports violation count, first violating index and an optional checksum.

Parameters:
- DATA_W, 32: element width in bits; must be a multiple of 8.
- ADDR_W, 32: byte-address width.
- LEN_W, 16: width of the length input; maximum length is 2^LEN_W-1.
- RD_LAT, 1: memory read latency in cycles, 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle start request.
- base_addr  in  ADDR_W  byte address of element 0; sampled at start.
- length  in  LEN_W  element count; sampled at start.
- descending  in  1  0 = nondecreasing required, 1 = nonincreasing required; sampled at start.
- signed_cmp  in  1  1 = two's-complement compare; sampled at start.
- mem_rd  out  1  read strobe to memory.
- mem_addr  out  ADDR_W  read byte address.
- mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after mem_rd.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at scan end.
- pass  out  1  result; held until the next start.
- viol_count  out  LEN_W  number of adjacent pairs out of order.
- first_viol  out  LEN_W  index i of the first pair (i-1, i) out of order; all-ones if none.

Behaviour:
- Reset values: mem_rd=0, mem_addr=0, busy=0, done=0, pass=0, viol_count=0, first_viol=all-ones; FSM goes to IDLE.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - start=1 latches all sampled inputs, clears results and sets busy=1 the next cycle.
  - If length==0, go to FIN. Otherwise go to ISSUE.
- ISSUE:
  - One read per cycle: mem_rd=1 with mem_addr = base + k*(DATA_W/8), k=0..length-1.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - After issuing index length-1, go to DRAIN.
- DRAIN: wait until all outstanding reads have returned, then go to FIN.
  - Returns are tracked by an RD_LAT-deep valid/index shift register.
- Compare pipeline:
  - Each returned element is compared with the previously returned element, held in a register with a has_prev flag.
  - Violation condition: prev>cur when ascending; prev<cur when descending. Equal values never violate.
  - On a violation, increment viol_count, saturating at all-ones. first_viol captures the index only on the first violation.
- FIN: done=1 for exactly one cycle; pass=(viol_count==0) [AND checksum match, see below]; busy=0; return to IDLE.
- Total latency for length L>0: done rises L+RD_LAT+2 cycles after the start edge.
- start while busy is ignored and does not restart the scan.
- start in the same cycle as done is accepted; the new scan begins the next cycle.
- Reset asserted mid-scan aborts immediately: mem_rd drops asynchronously and outputs return to their reset values.
- length==1: one read, no compare, pass=1.

Optional Feature:
- Macro: ARRAY_ORDER_CHECKER_SUM_EN.
- When defined:
  - Adds input exp_sum [DATA_W] (sampled at start) and output sum [DATA_W].
  - sum accumulates all returned elements modulo 2^DATA_W.
  - pass additionally requires sum==exp_sum, which detects lost or duplicated elements after a sort.
- When undefined: neither port exists and pass depends only on ordering.

Decomposition:
- Shared package array_check_pkg holds:
  - the FSM state enum (IDLE/ISSUE/DRAIN/FIN);
  - the localparam BYTES_PER_ELEM function of DATA_W;
  - the all-ones sentinel constant for first_viol.
- One natural sub-module: order_cmp, a combinational signed/unsigned, ascending/descending violation comparator. It is instantiated once.
- The rest (issue counter, latency shift register, accumulators) is flat.

Test Plan:
- Ascending: preload 10 words at 4336 with 1..10; start base=4336, len=10, desc=0 -> pass=1, viol_count=0, first_viol=16'hFFFF; done exactly 10+RD_LAT+2 cycles after start.
- Unsorted quicksort input: preload {5,3,8,1,9,2,7,4,6,0} -> pass=0, viol_count=5, first_viol=1.
- Signed, descending: preload {7,0,-1,-5} with desc=1, signed=1 -> pass=1. Same data with signed=0 -> pass=0, viol_count=1, first_viol=2.
- Boundaries: len=0 -> done 2 cycles after start, zero mem_rd pulses, pass=1. len=1 -> exactly one read, pass=1. A start pulse during busy -> ignored, reads unchanged.
- Reset mid-scan: drop rst after 3 reads -> mem_rd=0, busy=0 immediately. A new start after release rescans from index 0 with correct results.
- With ARRAY_ORDER_CHECKER_SUM_EN, RD_LAT=2:
  - Sorted 1..10 with exp_sum=55 -> pass=1.
  - Sorted {1,2,2,4,...,10} (3 replaced by duplicate 2) with exp_sum=55 -> sum=54, pass=0, viol_count=0.
